mod_updown_counter: RTL and testbench

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/mod_updown_counter.sv | 110 +++++++++++
 tb/tb_mod_updown_counter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with a STOP/RUN gate on the count tick, manual adjust,
// synchronous clear/load and registered one-cycle carry/borrow wrap pulses.
module mod_updown_counter #(
    parameter int MODULO     = 60,
    parameter int BIT_WIDTH  = 7,
    parameter int INIT_VALUE = 0,
    parameter bit AUTO_RUN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tick,
    input  logic                 i_down,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_inc,
    input  logic                 i_dec,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [BIT_WIDTH-1:0] i_load_value,
    output logic [BIT_WIDTH-1:0] o_value,
    output logic                 o_carry,
    output logic                 o_borrow,
    output logic                 o_running
);

    localparam logic [BIT_WIDTH-1:0] MAX_VAL  = BIT_WIDTH'(MODULO - 1);
    localparam logic [BIT_WIDTH-1:0] INIT_VAL = BIT_WIDTH'(INIT_VALUE);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = AUTO_RUN ? ST_RUN : ST_STOP;

    state_t                 state_q, state_d;
    logic [BIT_WIDTH-1:0]   value_q, value_d;
    logic                   carry_q, carry_d;
    logic                   borrow_q, borrow_d;
    logic                   tick_ok;

    // >= rather than == so an out-of-range value can never propagate past one step.
    function automatic logic [BIT_WIDTH-1:0] wrap_up(input logic [BIT_WIDTH-1:0] v);
        return (v >= MAX_VAL) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [BIT_WIDTH-1:0] wrap_dn(input logic [BIT_WIDTH-1:0] v);
        return (v == '0 || v > MAX_VAL) ? MAX_VAL : v - 1'b1;
    endfunction

    function automatic logic [BIT_WIDTH-1:0] clamp_load(input logic [BIT_WIDTH-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RESET_STATE;
            value_q  <= INIT_VAL;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    // Simultaneous start and stop cancel out and leave the state alone.
    always_comb begin
        state_d = state_q;
        if (i_start && !i_stop) begin
            state_d = ST_RUN;
        end else if (i_stop && !i_start) begin
            state_d = ST_STOP;
        end
    end

    // Tick gating uses the current state, so a start in the same cycle does not enable it.
    assign tick_ok = i_tick && (state_q == ST_RUN);

    always_comb begin
        value_d  = value_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (i_clear) begin
            value_d = INIT_VAL;
        end else if (i_load) begin
            value_d = clamp_load(i_load_value);
        end else if (tick_ok) begin
            if (i_down) begin
                borrow_d = (value_q == '0);
                value_d  = wrap_dn(value_q);
            end else begin
                carry_d = (value_q >= MAX_VAL);
                value_d = wrap_up(value_q);
            end
        end else if (i_inc && !i_dec) begin
            value_d = wrap_up(value_q);
        end else if (i_dec && !i_inc) begin
            value_d = wrap_dn(value_q);
        end
    end

    assign o_value   = value_q;
    assign o_carry   = carry_q;
    assign o_borrow  = borrow_q;
    assign o_running = (state_q == ST_RUN);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: a modulo-arithmetic reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_mod_updown_counter;

    localparam int M = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick = 0, down = 0, start = 0, stop = 0;
    logic       inc = 0, dec = 0, clear = 0, load = 0;
    logic [6:0] lv = '0;

    logic [6:0] o_value, b_value;
    logic       o_carry, o_borrow, o_running;
    logic       b_carry, b_borrow, b_running;

    int n_cmp  = 0;
    int n_fail = 0;

    mod_updown_counter u_dut (
        .clk(clk), .rst(rst), .i_tick(tick), .i_down(down), .i_start(start),
        .i_stop(stop), .i_inc(inc), .i_dec(dec), .i_clear(clear), .i_load(load),
        .i_load_value(lv), .o_value(o_value), .o_carry(o_carry),
        .o_borrow(o_borrow), .o_running(o_running)
    );

    mod_updown_counter #(.AUTO_RUN(1'b0)) u_dut_stop (
        .clk(clk), .rst(rst), .i_tick(tick), .i_down(down), .i_start(start),
        .i_stop(stop), .i_inc(inc), .i_dec(dec), .i_clear(clear), .i_load(load),
        .i_load_value(lv), .o_value(b_value), .o_carry(b_carry),
        .o_borrow(b_borrow), .o_running(b_running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain modulo arithmetic on integers.
    int m_val = 0;
    bit m_run = 1'b1;
    bit m_c   = 1'b0;
    bit m_b   = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_val = 0; m_run = 1'b1; m_c = 1'b0; m_b = 1'b0;
        end else begin
            m_c = 1'b0;
            m_b = 1'b0;
            if (clear)                  m_val = 0;
            else if (load)              m_val = (int'(lv) > M - 1) ? M - 1 : int'(lv);
            else if (tick && m_run) begin
                if (down) begin m_b = (m_val == 0);     m_val = (m_val + M - 1) % M; end
                else      begin m_c = (m_val == M - 1); m_val = (m_val + 1) % M;     end
            end
            else if (inc && !dec)       m_val = (m_val + 1) % M;
            else if (dec && !inc)       m_val = (m_val + M - 1) % M;
            if (start && !stop)         m_run = 1'b1;
            else if (stop && !start)    m_run = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("cmp_value",   o_value,   m_val);
        check("cmp_carry",   o_carry,   m_c);
        check("cmp_borrow",  o_borrow,  m_b);
        check("cmp_running", o_running, m_run);
        check("cmp_no_carry_and_borrow", o_carry & o_borrow, 0);
        check("cmp_range",   (o_value < M), 1);
    end

    task automatic step();
        @(negedge clk);
        tick = 0; down = 0; start = 0; stop = 0;
        inc = 0; dec = 0; clear = 0; load = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_value",        o_value,   0);
        check("reset_carry",        o_carry,   0);
        check("reset_running",      o_running, 1);
        check("reset_running_auto0", b_running, 0);
        rst = 1'b1;

        // Sixty up-ticks: 1..59 then wrap to 0 with carry.
        for (int i = 0; i < M; i++) begin
            tick = 1; step();
            check("up_value", o_value, (i + 1) % M);
            check("up_carry", o_carry, (i == M - 1));
        end
        step();
        check("carry_drop", o_carry, 0);

        tick = 1; down = 1; step();
        check("down_wrap_value",  o_value,  59);
        check("down_wrap_borrow", o_borrow, 1);
        check("down_wrap_carry",  o_carry,  0);
        step();
        check("borrow_drop", o_borrow, 0);

        stop = 1; step();
        check("stop_running", o_running, 0);
        for (int i = 0; i < 5; i++) begin
            tick = 1; step();
            check("stopped_tick_value", o_value, 59);
            check("stopped_tick_carry", o_carry, 0);
        end
        inc = 1; step();
        check("inc_wrap_value", o_value, 0);
        check("inc_wrap_carry", o_carry, 0);
        start = 1; tick = 1; step();
        check("start_tick_value",   o_value,   0);
        check("start_tick_running", o_running, 1);
        start = 1; stop = 1; step();
        check("start_stop_running", o_running, 1);

        load = 1; lv = 7'd75; step();
        check("load_clamp", o_value, 59);
        clear = 1; load = 1; lv = 7'd20; step();
        check("clear_over_load", o_value, 0);
        load = 1; lv = 7'd10; tick = 1; step();
        check("load_over_tick", o_value, 10);
        tick = 1; dec = 1; step();
        check("tick_beats_dec", o_value, 11);
        inc = 1; dec = 1; step();
        check("inc_dec_cancel", o_value, 11);
        tick = 1; down = 1; inc = 1; step();
        check("tickdn_beats_inc", o_value, 10);
        dec = 1; step();
        check("dec_value", o_value, 9);

        // Mixed traffic checked by the model alone.
        for (int i = 0; i < 120; i++) begin
            tick  = ($urandom_range(0, 3) != 0);
            down  = $urandom_range(0, 1);
            inc   = $urandom_range(0, 1);
            dec   = $urandom_range(0, 1);
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 9) == 0);
            clear = ($urandom_range(0, 19) == 0);
            load  = ($urandom_range(0, 14) == 0);
            lv    = 7'($urandom_range(0, 127));
            step();
        end
        start = 1; step();

        // Asynchronous reset at 33 with a tick pending.
        load = 1; lv = 7'd32; step();
        tick = 1; step();
        check("pre_reset_value", o_value, 33);
        tick = 1;
        #2 rst = 1'b0;
        #1;
        check("async_value",  o_value,  0);
        check("async_carry",  o_carry,  0);
        @(negedge clk);
        check("held_reset_value", o_value, 0);
        tick = 0; rst = 1'b1;
        step();
        check("post_release_value", o_value, 0);

        // Asynchronous reset while a carry pulse is high.
        load = 1; lv = 7'd59; step();
        tick = 1; step();
        check("carry_pending", o_carry, 1);
        #2 rst = 1'b0;
        #1;
        check("async_carry_clear", o_carry,   0);
        check("async_value2",      o_value,   0);
        check("async_running",     o_running, 1);
        check("async_running_auto0", b_running, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
